// File: rtl/game_pkg.sv
// Shared game-level types and constants for the turn scheduler
// and the renderer controller.
package game_pkg;

  localparam int START_X   = 20;
  localparam int TILE_PX   = 60;
  localparam int FLAG_TILE = 10;
  localparam int FLAG_X    = 620;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_GAME_OVER
  } sched_state_t;

  typedef enum logic [1:0] {
    RND_IDLE,
    RND_LOAD,
    RND_ANIM,
    RND_DONE
  } render_state_t;

  function automatic logic [9:0] tile_to_px(
    input logic [3:0] tile,
    input int         start_x,
    input int         tile_px
  );
    return 10'(start_x + int'(tile) * tile_px);
  endfunction

endpackage

// File: rtl/turn_scheduler.sv
// Two-player turn sequencer: takes move requests, tracks tiles,
// hands one target per turn to the renderer and waits for it.
module turn_scheduler #(
  parameter int START_X        = game_pkg::START_X,
  parameter int TILE_PX        = game_pkg::TILE_PX,
  parameter int FLAG_TILE      = game_pkg::FLAG_TILE,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       move_req,
  input  logic [1:0] move_steps,
  input  logic       new_game,
  input  logic       turn_done,
  output logic       pos_valid,
  output logic       active_player,
  output logic [9:0] player1_pos_x,
  output logic [9:0] player2_pos_x,
  output logic       busy,
  output logic       game_over,
  output logic       winner,
  output logic       req_dropped,
  output logic       timeout_err
);
  import game_pkg::*;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] FLAG = 4'(FLAG_TILE);
  localparam logic [9:0] PX0 = 10'(START_X);

  sched_state_t  state;
  logic [3:0]    tile1;
  logic [3:0]    tile2;
  logic [CW-1:0] to_cnt;

  logic [3:0] act_tile;
  logic [4:0] sum;
  logic [3:0] next_tile;
  logic       finish;

  always_comb begin
    act_tile  = active_player ? tile2 : tile1;
    sum       = {1'b0, act_tile} + {3'b000, move_steps};
    next_tile = (sum > {1'b0, FLAG}) ? FLAG : sum[3:0];
    finish    = turn_done || (to_cnt == TO_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      tile1         <= '0;
      tile2         <= '0;
      to_cnt        <= '0;
      player1_pos_x <= PX0;
      player2_pos_x <= PX0;
      active_player <= 1'b0;
      pos_valid     <= 1'b0;
      busy          <= 1'b0;
      game_over     <= 1'b0;
      winner        <= 1'b0;
      req_dropped   <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      pos_valid   <= 1'b0;
      req_dropped <= 1'b0;
      if (new_game) begin
        state         <= S_IDLE;
        tile1         <= '0;
        tile2         <= '0;
        to_cnt        <= '0;
        player1_pos_x <= PX0;
        player2_pos_x <= PX0;
        active_player <= 1'b0;
        busy          <= 1'b0;
        game_over     <= 1'b0;
        winner        <= 1'b0;
        timeout_err   <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (move_req) begin
              if (move_steps == 2'd0) begin
                req_dropped <= 1'b1;
              end else begin
                if (active_player) begin
                  tile2         <= next_tile;
                  player2_pos_x <= tile_to_px(next_tile, START_X, TILE_PX);
                end else begin
                  tile1         <= next_tile;
                  player1_pos_x <= tile_to_px(next_tile, START_X, TILE_PX);
                end
                busy  <= 1'b1;
                state <= S_ISSUE;
              end
            end
          end
          S_ISSUE: begin
            req_dropped <= move_req;
            pos_valid   <= 1'b1;
            to_cnt      <= '0;
            state       <= S_WAIT_DONE;
          end
          S_WAIT_DONE: begin
            req_dropped <= move_req;
            if (finish) begin
              // a real turn_done wins over a simultaneous expiry
              if (!turn_done) timeout_err <= 1'b1;
              busy <= 1'b0;
              if (act_tile == FLAG) begin
                game_over <= 1'b1;
                winner    <= active_player;
                state     <= S_GAME_OVER;
              end else begin
                active_player <= ~active_player;
                state         <= S_IDLE;
              end
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          S_GAME_OVER: begin
            req_dropped <= move_req;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler with a short timeout.
module tb_turn_scheduler;

  logic       clk;
  logic       rst_n;
  logic       move_req;
  logic [1:0] move_steps;
  logic       new_game;
  logic       turn_done;
  logic       pos_valid;
  logic       active_player;
  logic [9:0] player1_pos_x;
  logic [9:0] player2_pos_x;
  logic       busy;
  logic       game_over;
  logic       winner;
  logic       req_dropped;
  logic       timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  turn_scheduler #(.TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .move_req      (move_req),
    .move_steps    (move_steps),
    .new_game      (new_game),
    .turn_done     (turn_done),
    .pos_valid     (pos_valid),
    .active_player (active_player),
    .player1_pos_x (player1_pos_x),
    .player2_pos_x (player2_pos_x),
    .busy          (busy),
    .game_over     (game_over),
    .winner        (winner),
    .req_dropped   (req_dropped),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " pos_valid"}, 16'(pos_valid), 16'd0);
    chk({tag, " busy"}, 16'(busy), 16'd0);
    chk({tag, " p1x"}, 16'(player1_pos_x), 16'd20);
    chk({tag, " p2x"}, 16'(player2_pos_x), 16'd20);
    chk({tag, " active"}, 16'(active_player), 16'd0);
    chk({tag, " game_over"}, 16'(game_over), 16'd0);
    chk({tag, " winner"}, 16'(winner), 16'd0);
    chk({tag, " timeout_err"}, 16'(timeout_err), 16'd0);
  endtask

  // issue a move and follow it to the WAIT_DONE state
  task automatic do_turn(input string tag, input logic [1:0] steps,
                         input logic pl, input int px);
    move_req   = 1'b1;
    move_steps = steps;
    tick();
    move_req   = 1'b0;
    move_steps = 2'd0;
    chk({tag, " busy@N"}, 16'(busy), 16'd1);
    chk({tag, " pv@N"}, 16'(pos_valid), 16'd0);
    chk({tag, " px@N"},
        16'(pl ? player2_pos_x : player1_pos_x), 16'(px));
    tick();
    chk({tag, " pv@N+1"}, 16'(pos_valid), 16'd1);
    chk({tag, " act@N+1"}, 16'(active_player), 16'(pl));
    tick();
    chk({tag, " pv@N+2"}, 16'(pos_valid), 16'd0);
    chk({tag, " busy@N+2"}, 16'(busy), 16'd1);
  endtask

  task automatic finish_turn(input string tag, input logic next_pl);
    turn_done = 1'b1;
    tick();
    turn_done = 1'b0;
    chk({tag, " busy"}, 16'(busy), 16'd0);
    chk({tag, " act"}, 16'(active_player), 16'(next_pl));
  endtask

  initial begin
    rst_n      = 1'b0;
    move_req   = 1'b0;
    move_steps = 2'd0;
    new_game   = 1'b0;
    turn_done  = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    chk("reset req_dropped", 16'(req_dropped), 16'd0);
    rst_n = 1'b1;
    tick();

    do_turn("t1 p1+1", 2'd1, 1'b0, 80);
    finish_turn("t1 done", 1'b1);

    do_turn("t2 p2+2", 2'd2, 1'b1, 140);
    finish_turn("t2a done", 1'b0);
    do_turn("t2 p1+3", 2'd3, 1'b0, 260);
    finish_turn("t2b done", 1'b1);

    move_req = 1'b1;
    move_steps = 2'd0;
    tick();
    move_req = 1'b0;
    chk("zero-step drop", 16'(req_dropped), 16'd1);
    chk("zero-step busy", 16'(busy), 16'd0);
    chk("zero-step p2x", 16'(player2_pos_x), 16'd140);
    tick();
    chk("zero-step pulse end", 16'(req_dropped), 16'd0);
    chk("zero-step no pv", 16'(pos_valid), 16'd0);

    do_turn("t3 p2+1", 2'd1, 1'b1, 200);
    finish_turn("t3a", 1'b0);
    do_turn("t3 p1+3", 2'd3, 1'b0, 440);
    finish_turn("t3b", 1'b1);
    do_turn("t3 p2+1b", 2'd1, 1'b1, 260);
    finish_turn("t3c", 1'b0);
    do_turn("t3 p1+2", 2'd2, 1'b0, 560);
    finish_turn("t3d", 1'b1);
    do_turn("t3 p2+1c", 2'd1, 1'b1, 320);
    finish_turn("t3e", 1'b0);
    do_turn("t3 clamp", 2'd3, 1'b0, 620);
    finish_turn("t3 win", 1'b0);
    chk("t3 game_over", 16'(game_over), 16'd1);
    chk("t3 winner", 16'(winner), 16'd0);

    move_req = 1'b1;
    move_steps = 2'd1;
    tick();
    move_req = 1'b0;
    chk("t3 go drop", 16'(req_dropped), 16'd1);
    chk("t3 go p1x", 16'(player1_pos_x), 16'd620);
    tick();
    chk("t3 go no pv", 16'(pos_valid), 16'd0);
    chk("t3 go busy", 16'(busy), 16'd0);

    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk_idle("new_game after win");

    do_turn("t4 p1+1", 2'd1, 1'b0, 80);
    move_req = 1'b1;
    move_steps = 2'd2;
    tick();
    move_req = 1'b0;
    chk("t4 wait drop", 16'(req_dropped), 16'd1);
    chk("t4 wait busy", 16'(busy), 16'd1);
    chk("t4 wait p1x", 16'(player1_pos_x), 16'd80);
    move_req = 1'b1;
    turn_done = 1'b1;
    tick();
    move_req = 1'b0;
    turn_done = 1'b0;
    chk("t4 coinc drop", 16'(req_dropped), 16'd1);
    chk("t4 coinc act", 16'(active_player), 16'd1);
    chk("t4 coinc busy", 16'(busy), 16'd0);
    chk("t4 coinc p1x", 16'(player1_pos_x), 16'd80);
    chk("t4 coinc p2x", 16'(player2_pos_x), 16'd20);

    do_turn("t5 p2+2", 2'd2, 1'b1, 140);
    for (int i = 0; i < 14; i++) tick();
    chk("t5 pre-timeout err", 16'(timeout_err), 16'd0);
    chk("t5 pre-timeout busy", 16'(busy), 16'd1);
    tick();
    chk("t5 timeout err", 16'(timeout_err), 16'd1);
    chk("t5 timeout busy", 16'(busy), 16'd0);
    chk("t5 timeout act", 16'(active_player), 16'd0);
    turn_done = 1'b1;
    tick();
    turn_done = 1'b0;
    chk("t5 stray done act", 16'(active_player), 16'd0);
    chk("t5 stray done busy", 16'(busy), 16'd0);
    chk("t5 sticky err", 16'(timeout_err), 16'd1);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk_idle("t5 new_game");

    do_turn("t6 p1+1", 2'd1, 1'b0, 80);
    rst_n = 1'b0;
    #1;
    chk_idle("t6 async reset");
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6 after reset pv", 16'(pos_valid), 16'd0);

    move_req = 1'b1;
    move_steps = 2'd2;
    tick();
    move_req = 1'b0;
    chk("t6 issue p1x", 16'(player1_pos_x), 16'd140);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk_idle("t6 ng in issue");
    tick();
    chk("t6 no late pv", 16'(pos_valid), 16'd0);
    chk("t6 still idle", 16'(busy), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
